// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one add-shift signed multiplier datapath among NREQ requesters.
// Optional build macro MULT_SHARE_SKIP_ZERO_EN: skip the ADD step for zero multiplier bits.
module mult_share_ctrl #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req_i,
    input  logic [NREQ*NBITS-1:0] A_in_i,
    input  logic [NREQ*NBITS-1:0] B_in_i,
    input  logic                  M_i,
    input  logic [2*NBITS-1:0]    Prod_in_i,
    output logic [NBITS-1:0]      Op_S_o,
    output logic [NBITS-1:0]      Op_B_o,
    output logic                  Clr_Ld_o,
    output logic                  Add_o,
    output logic                  Fn_o,
    output logic                  Shift_En_o,
    output logic [NREQ-1:0]       Grant_o,
    output logic                  Busy_o,
    output logic [NREQ-1:0]       Done_o,
    output logic [2*NBITS-1:0]    Result_o
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(NBITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAdd,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [2*NBITS-1:0] result_q, result_d;

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    pick;
    logic [PtrW-1:0]    pick_idx;
    logic [PtrW-1:0]    pick_next;
    logic               pick_valid;
    logic               owner_req;
    logic               last_bit;

    function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return PtrW'(s);
    endfunction

    // Round-robin pick; the requester being told Done this cycle must not be re-granted at once.
    always_comb begin
        eligible   = Req_i & ~done_q;
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_valid && eligible[wrap_add(ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(ptr_q, k);
            end
        end
        pick      = pick_valid ? (NREQ'(1) << pick_idx) : '0;
        pick_next = wrap_add(pick_idx, 1);
    end

    assign owner_req = |(Req_i & grant_q);
    assign last_bit  = (cnt_q == LastBit);

    // Operand steering, and-or mux on the one-hot grant so an idle grant yields zero.
    always_comb begin
        Op_S_o = '0;
        Op_B_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            Op_S_o = Op_S_o | (A_in_i[i*NBITS +: NBITS] & {NBITS{grant_q[i]}});
            Op_B_o = Op_B_o | (B_in_i[i*NBITS +: NBITS] & {NBITS{grant_q[i]}});
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick;
                    ptr_d   = pick_next;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d = '0;
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else begin
`ifdef MULT_SHARE_SKIP_ZERO_EN
                    // B is only being loaded now, so look at the operand itself.
                    state_d = Op_B_o[0] ? StAdd : StShift;
`else
                    state_d = StAdd;
`endif
                end
            end
            StAdd: begin
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                cnt_d = cnt_q + CntW'(1);
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else if (last_bit) begin
                    state_d = StDone;
                end else begin
`ifdef MULT_SHARE_SKIP_ZERO_EN
                    // B[1] now becomes M after this shift.
                    state_d = Prod_in_i[1] ? StAdd : StShift;
`else
                    state_d = StAdd;
`endif
                end
            end
            StDone: begin
                result_d = Prod_in_i;
                done_d   = grant_q;
                grant_d  = '0;
                state_d  = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        Clr_Ld_o   = 1'b0;
        Add_o      = 1'b0;
        Fn_o       = 1'b0;
        Shift_En_o = 1'b0;
        unique case (state_q)
            StLoad:  Clr_Ld_o = 1'b1;
            StAdd: begin
                Add_o = M_i;
                Fn_o  = last_bit;
            end
            StShift: Shift_En_o = 1'b1;
            default: ;
        endcase
    end

    assign Grant_o  = grant_q;
    assign Busy_o   = (state_q != StIdle);
    assign Done_o   = done_q;
    assign Result_o = result_q;

`ifndef SYNTHESIS
    a_ctrl_excl: assert property (@(posedge Clk) disable iff (Reset)
        $onehot0({Clr_Ld_o, Add_o, Shift_En_o}));
    a_grant_onehot: assert property (@(posedge Clk) disable iff (Reset) $onehot0(grant_q));
    a_done_onehot: assert property (@(posedge Clk) disable iff (Reset) $onehot0(done_q));
    a_busy_grant: assert property (@(posedge Clk) disable iff (Reset)
        (state_q != StIdle) == (grant_q != '0));
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural add-shift datapath, scoreboard of expected products.
module tb_mult_share_ctrl;
    localparam int unsigned NR = 4;
    localparam int unsigned NB = 8;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [NR-1:0]      req;
    logic [NR*NB-1:0]   a_in;
    logic [NR*NB-1:0]   b_in;
    logic               m;
    logic [2*NB-1:0]    prod_in;
    logic [NB-1:0]      op_s;
    logic [NB-1:0]      op_b;
    logic               clr_ld;
    logic               add;
    logic               fn;
    logic               shift_en;
    logic [NR-1:0]      grant;
    logic               busy;
    logic [NR-1:0]      done;
    logic [2*NB-1:0]    result;

    mult_share_ctrl #(.NREQ(NR), .NBITS(NB)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req_i      (req),
        .A_in_i     (a_in),
        .B_in_i     (b_in),
        .M_i        (m),
        .Prod_in_i  (prod_in),
        .Op_S_o     (op_s),
        .Op_B_o     (op_b),
        .Clr_Ld_o   (clr_ld),
        .Add_o      (add),
        .Fn_o       (fn),
        .Shift_En_o (shift_en),
        .Grant_o    (grant),
        .Busy_o     (busy),
        .Done_o     (done),
        .Result_o   (result)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Shared datapath: A, B registers and X sign flop; never reset, reloaded on Clr_Ld.
    logic [NB-1:0] dp_a = '0;
    logic [NB-1:0] dp_b = '0;
    logic          dp_x = 1'b0;
    logic [NB:0]   dp_sum;
    assign dp_sum = fn ? ({dp_a[NB-1], dp_a} - {op_s[NB-1], op_s})
                       : ({dp_a[NB-1], dp_a} + {op_s[NB-1], op_s});
    always @(posedge Clk) begin
        if (clr_ld) begin
            dp_a <= '0;
            dp_x <= 1'b0;
            dp_b <= op_b;
        end else if (add) begin
            dp_a <= dp_sum[NB-1:0];
            dp_x <= dp_sum[NB];
        end else if (shift_en) begin
            dp_a <= {dp_x, dp_a[NB-1:1]};
            dp_b <= {dp_a[0], dp_b[NB-1:1]};
        end
    end
    assign m       = dp_b[0];
    assign prod_in = {dp_a, dp_b};

    typedef struct {
        int unsigned     who;
        logic [2*NB-1:0] prod;
        int unsigned     due;
    } exp_t;

    exp_t            sb[$];
    logic [2*NB-1:0] last_result = '0;
    int unsigned     n_checks = 0;
    int unsigned     n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [2*NB-1:0] mul_ref(input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic signed [2*NB-1:0] sa;
        logic signed [2*NB-1:0] sbv;
        sa  = {{NB{a[NB-1]}}, a};
        sbv = {{NB{b[NB-1]}}, b};
        return sa * sbv;
    endfunction

    function automatic int unsigned lat(input logic [NB-1:0] b);
`ifdef MULT_SHARE_SKIP_ZERO_EN
        return NB + $countones(b) + 3;
`else
        return 2 * NB + 3;
`endif
    endfunction

    // Monitor: every Done pulse must match the head of the scoreboard.
    initial forever begin
        @(negedge Clk);
        check_eq("ctrl_excl", 32'($countones({clr_ld, add, shift_en}) > 1), 0);
        if (done != '0) begin
            if (sb.size() == 0) begin
                check_eq("done_unexpected", 32'(done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_who", 32'(done), 32'(1) << e.who);
                check_eq("result", 32'(result), 32'(e.prod));
                check_eq("done_cycle", cyc, e.due);
                last_result = e.prod;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input int unsigned who, input logic [NB-1:0] a,
                            input logic [NB-1:0] b, input int unsigned due);
        exp_t e;
        a_in[who*NB +: NB] = a;
        b_in[who*NB +: NB] = b;
        e.who  = who;
        e.prod = mul_ref(a, b);
        e.due  = due;
        sb.push_back(e);
        req[who] = 1'b1;
    endtask

    task automatic wait_sb(input int unsigned left, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            step();
            if (sb.size() <= left) break;
        end
        check_eq("sb_pending", 32'(sb.size()), 32'(left));
        while (sb.size() > left) void'(sb.pop_back());
    endtask

    task automatic wait_shifts(input int unsigned n, output bit ok);
        int unsigned seen;
        seen = 0;
        ok   = 1'b0;
        for (int unsigned i = 0; i < 100 && !ok; i++) begin
            @(negedge Clk);
            if (shift_en) seen++;
            if (seen == n) ok = 1'b1;
        end
    endtask

    task automatic run_single(input int unsigned who, input logic [NB-1:0] a,
                              input logic [NB-1:0] b);
        start_op(who, a, b, cyc + lat(b));
        @(negedge Clk);
        check_eq("idle_busy", 32'(busy), 0);
        @(negedge Clk);
        check_eq("grant", 32'(grant), 32'(1) << who);
        check_eq("load_clr_ld", 32'(clr_ld), 1);
        check_eq("load_busy", 32'(busy), 1);
        check_eq("op_s", 32'(op_s), 32'(a));
        check_eq("op_b", 32'(op_b), 32'(b));
        wait_sb(0, 64);
        req[who] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_result"}, 32'(result), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_ctrl"}, 32'({clr_ld, add, fn, shift_en}), 0);
        check_eq({tag, "_ops"}, 32'({op_s, op_b}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int unsigned c0;
        Reset = 1'b1;
        req   = '0;
        a_in  = 32'hA5C3_5A3C;
        b_in  = 32'h1234_5678;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        Reset = 1'b0;
        step();

        run_single(0, 8'h07, 8'h03);
        run_single(1, 8'hFF, 8'hFF);
        run_single(1, 8'h80, 8'h80);
        run_single(3, 8'h7F, 8'h81);
        run_single(2, 8'h05, 8'h01);
        run_single(0, 8'h05, 8'h00);
        for (int i = 0; i < 4; i++) begin
            run_single($urandom_range(0, NR - 1), 8'($urandom), 8'($urandom));
        end

        // Three requesters held from reset: back-to-back grants 0,1,2,0.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        c0 = cyc;
        start_op(0, 8'h13, 8'hF1, c0 + lat(8'hF1));
        start_op(1, 8'hE7, 8'h2B, c0 + lat(8'hF1) + lat(8'h2B));
        start_op(2, 8'h40, 8'hC0, c0 + lat(8'hF1) + lat(8'h2B) + lat(8'hC0));
        start_op(0, 8'h13, 8'hF1, c0 + 2 * lat(8'hF1) + lat(8'h2B) + lat(8'hC0));
        wait_sb(0, 128);
        req = '0;
        repeat (3) step();
        check_eq("held_idle_busy", 32'(busy), 0);

        // Abort: Req2 drops during the 5th SHIFT.
        a_in[2*NB +: NB] = 8'h33;
        b_in[2*NB +: NB] = 8'h5A;
        req[2] = 1'b1;
        wait_shifts(5, ok);
        check_eq("abort_shift_seen", 32'(ok), 1);
        req[2] = 1'b0;
        @(negedge Clk);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_grant", 32'(grant), 0);
        repeat (30) step();
        check_eq("abort_result", 32'(result), 32'(last_result));

        // Pointer kept its advanced value (3): Req1 and Req3 served as 3 then 1.
        c0 = cyc;
        start_op(3, 8'h9C, 8'h0F, c0 + lat(8'h0F));
        start_op(1, 8'h21, 8'hE0, c0 + lat(8'h0F) + lat(8'hE0));
        wait_sb(1, 64);
        req[3] = 1'b0;
        wait_sb(0, 64);
        req[1] = 1'b0;
        step();

        // Reset pulse mid-ADD, then a normal operation.
        start_op(0, 8'h11, 8'h7F, cyc + lat(8'h7F));
        wait_shifts(1, ok);
        check_eq("rst_shift_seen", 32'(ok), 1);
        step();
        Reset = 1'b1;
        sb.delete();
        req = '0;
        #1;
        check_all_zero("midrst");
        @(negedge Clk);
        Reset = 1'b0;
        last_result = '0;
        step();
        run_single(0, 8'h11, 8'h7F);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
